// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo
//   Decodes PS/2 set-2 scancode bytes into key events and queues them in a
//   first-word-fall-through FIFO for the CPU.
//
//   Optional build macro: KBD_EVENT_FIFO_REPEAT_FILTER_EN
//     When defined, typematic repeats of the currently held key are dropped.
//
// Ports
//   clk, rst            system clock / async active-high reset
//   kd[7:0], kv         scancode byte and its one-cycle strobe
//   ev_code/ext/brk     head event fields (0 while empty)
//   ev_valid, ev_ready  FWFT handshake, pop on valid & ready
//   ovf, ovf_clr        sticky drop flag and its clear (a drop wins over clear)
//   level               number of queued events, 0..DEPTH
module kbd_event_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            kd,
    input  logic                  kv,
    output logic [7:0]            ev_code,
    output logic                  ev_ext,
    output logic                  ev_brk,
    output logic                  ev_valid,
    input  logic                  ev_ready,
    output logic                  ovf,
    input  logic                  ovf_clr,
    output logic [DEPTH_LOG2:0]   level
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2+1)'(1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] EXT     = 3'd1;
    localparam logic [2:0] BRK     = 3'd2;
    localparam logic [2:0] EXT_BRK = 3'd3;
    localparam logic [2:0] SKIP    = 3'd4;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

    logic [2:0] st, st_nxt;
    logic [2:0] skip, skip_nxt;
    logic       dec_push;
    ev_t        dec_ev;
    logic       filler;

    // Keyboard housekeeping bytes (ACK, BAT result, echo, resend, errors).
    assign filler = (kd == 8'h00) || (kd == 8'hAA) || (kd == 8'hEE) ||
                    (kd == 8'hFA) || (kd == 8'hFE) || (kd == 8'hFF);

    always_comb begin
        st_nxt   = st;
        skip_nxt = skip;
        dec_push = 1'b0;
        dec_ev   = '0;
        if (kv) begin
            case (st)
                IDLE: begin
                    if (kd == 8'hE0)      st_nxt = EXT;
                    else if (kd == 8'hF0) st_nxt = BRK;
                    else if (kd == 8'hE1) begin
                        st_nxt   = SKIP;
                        skip_nxt = 3'd7;
                    end else if (!filler) begin
                        dec_push = 1'b1;
                        dec_ev   = '{ext: 1'b0, brk: 1'b0, code: kd};
                    end
                end
                EXT: begin
                    if (kd == 8'hF0) st_nxt = EXT_BRK;
                    else if (kd != 8'hE0) begin
                        dec_push = 1'b1;
                        dec_ev   = '{ext: 1'b1, brk: 1'b0, code: kd};
                        st_nxt   = IDLE;
                    end
                end
                BRK: begin
                    if (kd == 8'hE0) st_nxt = EXT_BRK;
                    else if (kd != 8'hF0) begin
                        dec_push = 1'b1;
                        dec_ev   = '{ext: 1'b0, brk: 1'b1, code: kd};
                        st_nxt   = IDLE;
                    end
                end
                EXT_BRK: begin
                    if (kd != 8'hE0 && kd != 8'hF0) begin
                        dec_push = 1'b1;
                        dec_ev   = '{ext: 1'b1, brk: 1'b1, code: kd};
                        st_nxt   = IDLE;
                    end
                end
                SKIP: begin
                    // Pause sends E1 plus 7 more bytes; swallow them all.
                    skip_nxt = skip - 3'd1;
                    if (skip == 3'd1) st_nxt = IDLE;
                end
                default: st_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= IDLE;
            skip <= 3'd0;
        end else begin
            st   <= st_nxt;
            skip <= skip_nxt;
        end
    end

    logic push_req;

`ifdef KBD_EVENT_FIFO_REPEAT_FILTER_EN
    logic       held;
    logic [8:0] held_key;
    logic       match;

    assign match    = held && (held_key == {dec_ev.ext, dec_ev.code});
    assign push_req = dec_push && !(match && !dec_ev.brk);

    // The held key tracks what the keyboard reports, even if the FIFO
    // happens to drop the event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held     <= 1'b0;
            held_key <= '0;
        end else if (dec_push) begin
            if (dec_ev.brk) begin
                if (match) held <= 1'b0;
            end else begin
                held     <= 1'b1;
                held_key <= {dec_ev.ext, dec_ev.code};
            end
        end
    end
`else
    assign push_req = dec_push;
`endif

    ev_t                   mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                  full, do_pop, do_push, drop;
    ev_t                   head;

    assign full    = (level == LVL_FULL);
    assign do_pop  = ev_valid && ev_ready;
    // When full, a same-cycle pop frees the slot being written.
    assign do_push = push_req && (!full || do_pop);
    assign drop    = push_req && full && !do_pop;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= dec_ev;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
            if (drop)         ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    // Head fields are forced to 0 while empty so stale or unwritten
    // storage never reaches the CPU.
    assign ev_valid = (level != '0);
    assign head     = ev_valid ? mem[rd_ptr] : '0;
    assign ev_code  = head.code;
    assign ev_ext   = head.ext;
    assign ev_brk   = head.brk;

endmodule

// File: tb/tb_kbd_event_fifo.sv
module tb_kbd_event_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] kd = '0;
    logic       kv = 1'b0;
    logic [7:0] ev_code;
    logic       ev_ext, ev_brk, ev_valid;
    logic       ev_ready = 1'b0;
    logic       ovf;
    logic       ovf_clr = 1'b0;
    logic [4:0] level;

    int errors = 0;
    int checks = 0;

    kbd_event_fifo #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst), .kd(kd), .kv(kv),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_brk(ev_brk),
        .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ovf(ovf), .ovf_clr(ovf_clr), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] kd;
        logic       kv;
        logic       rdy;
        logic       clr;
        logic       e_valid;
        logic [7:0] e_code;
        logic       e_ext;
        logic       e_brk;
        int         e_level;
        logic       e_ovf;
    } vec_t;

    vec_t vt [64];
    int   nv = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [7:0] d, input logic v, input logic r, input logic c,
                       input logic ev, input logic [7:0] code, input logic e, input logic b,
                       input int lvl, input logic o);
        vt[nv] = '{d, v, r, c, ev, code, e, b, lvl, o};
        nv++;
    endtask

    task automatic step(input logic [7:0] d, input logic v, input logic r, input logic c);
        kd = d; kv = v; ev_ready = r; ovf_clr = c;
        @(posedge clk);
        #1;
        kv = 1'b0; ev_ready = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic chk_head(input string name, input logic [7:0] code, input logic e,
                            input logic b);
        chk({name, ".valid"}, int'(ev_valid), 1);
        chk({name, ".code"},  int'(ev_code), int'(code));
        chk({name, ".ext"},   int'(ev_ext), int'(e));
        chk({name, ".brk"},   int'(ev_brk), int'(b));
    endtask

    initial begin
        // --- vector table: {kd, kv, ready, clr, valid, code, ext, brk, level, ovf}
        // make 1C, visible one cycle after the strobe, then pop
        add(8'h1C, 1, 0, 0, 1, 8'h1C, 0, 0, 1, 0);
        add(8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        // E0 F0 75 -> extended break
        add(8'hE0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(8'hF0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(8'h75, 1, 0, 0, 1, 8'h75, 1, 1, 1, 0);
        add(8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        // redundant E0 then make
        add(8'hE0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(8'hE0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(8'h12, 1, 0, 0, 1, 8'h12, 1, 0, 1, 0);
        add(8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        // F0 F0 E0 F0 34 -> BRK stays, E0 to EXT_BRK, F0 ignored
        add(8'hF0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(8'hF0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(8'hE0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(8'hF0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(8'h34, 1, 0, 0, 1, 8'h34, 1, 1, 1, 0);
        add(8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        // fillers, then pause sequence swallowed, then 1C
        add(8'hAA, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(8'hFA, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(8'hE1, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(8'h14, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(8'h77, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(8'hE1, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(8'hF0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(8'h14, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(8'hF0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(8'h77, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        add(8'h1C, 1, 0, 0, 1, 8'h1C, 0, 0, 1, 0);
        add(8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        // ready while empty: no effect
        add(8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
        // push and ready on empty: pop ignored, level 1
        add(8'h5A, 1, 1, 0, 1, 8'h5A, 0, 0, 1, 0);
        add(8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0);

        // --- reset state
        #12;
        chk("rst.valid", int'(ev_valid), 0);
        chk("rst.level", int'(level), 0);
        chk("rst.ovf",   int'(ovf), 0);
        chk("rst.code",  int'(ev_code), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < nv; i++) begin
            step(vt[i].kd, vt[i].kv, vt[i].rdy, vt[i].clr);
            chk($sformatf("v%0d.valid", i), int'(ev_valid), int'(vt[i].e_valid));
            chk($sformatf("v%0d.code",  i), int'(ev_code),  int'(vt[i].e_code));
            chk($sformatf("v%0d.ext",   i), int'(ev_ext),   int'(vt[i].e_ext));
            chk($sformatf("v%0d.brk",   i), int'(ev_brk),   int'(vt[i].e_brk));
            chk($sformatf("v%0d.level", i), int'(level),    vt[i].e_level);
            chk($sformatf("v%0d.ovf",   i), int'(ovf),      int'(vt[i].e_ovf));
        end

        // --- reset between E0 and 75 discards the prefix
        step(8'hE0, 1, 0, 0);
        rst = 1'b1;
        #2;
        chk("midrst.level", int'(level), 0);
        rst = 1'b0;
        step(8'h75, 1, 0, 0);
        chk_head("midrst.head", 8'h75, 0, 0);
        chk("midrst.level2", int'(level), 1);
        step(8'h00, 0, 1, 0);
        chk("midrst.drain", int'(level), 0);

        // --- overflow: 17 makes into 16 entries
        for (int i = 1; i <= 17; i++) step(8'(i), 1, 0, 0);
        chk("ovf.level", int'(level), 16);
        chk("ovf.set",   int'(ovf), 1);
        chk_head("ovf.head", 8'h01, 0, 0);
        // drop in the same cycle as the clear keeps ovf set
        step(8'h12, 1, 0, 1);
        chk("ovf.dropwins", int'(ovf), 1);
        chk("ovf.level2", int'(level), 16);
        step(8'h00, 0, 0, 1);
        chk("ovf.clr", int'(ovf), 0);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain%0d.code", i), int'(ev_code), i);
            step(8'h00, 0, 1, 0);
        end
        chk("drain.level", int'(level), 0);
        chk("drain.valid", int'(ev_valid), 0);

        // --- full with simultaneous push and pop
        for (int i = 1; i <= 16; i++) step(8'(i), 1, 0, 0);
        chk("full.level", int'(level), 16);
        step(8'h2A, 1, 1, 0);
        chk("fullpp.level", int'(level), 16);
        chk("fullpp.ovf",   int'(ovf), 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("fullpp%0d.code", i), int'(ev_code), (i < 15) ? i + 2 : 'h2A);
            step(8'h00, 0, 1, 0);
        end
        chk("fullpp.empty", int'(level), 0);

        // --- typematic repeat
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step(8'h1C, 1, 0, 0);
        step(8'h1C, 1, 0, 0);
        step(8'h1C, 1, 0, 0);
        step(8'hF0, 1, 0, 0);
        step(8'h1C, 1, 0, 0);
        step(8'h1C, 1, 0, 0);
`ifdef KBD_EVENT_FIFO_REPEAT_FILTER_EN
        chk("rep.level", int'(level), 3);
        chk_head("rep.e0", 8'h1C, 0, 0); step(8'h00, 0, 1, 0);
        chk_head("rep.e1", 8'h1C, 0, 1); step(8'h00, 0, 1, 0);
        chk_head("rep.e2", 8'h1C, 0, 0); step(8'h00, 0, 1, 0);
`else
        chk("rep.level", int'(level), 5);
        chk_head("rep.e0", 8'h1C, 0, 0); step(8'h00, 0, 1, 0);
        chk_head("rep.e1", 8'h1C, 0, 0); step(8'h00, 0, 1, 0);
        chk_head("rep.e2", 8'h1C, 0, 0); step(8'h00, 0, 1, 0);
        chk_head("rep.e3", 8'h1C, 0, 1); step(8'h00, 0, 1, 0);
        chk_head("rep.e4", 8'h1C, 0, 0); step(8'h00, 0, 1, 0);
`endif
        chk("rep.empty", int'(level), 0);
        chk("rep.ovf", int'(ovf), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/kbd_event_fifo.md
Name: kbd_event_fifo

Overview:
- Sits between the PS/2 keyboard receiver and the CPU.
- Consumes raw scancode bytes (kd/kv, one-cycle strobe per byte) and decodes PS/2 set-2 prefixes (E0 extended, F0 break, E1 pause).
- Each complete key event is pushed into a first-word-fall-through FIFO, presented to the CPU with a valid/ready handshake.
- Absorbs bursts while the CPU is busy writing the video/LED bus; flags lost events.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 16 entries).

Ports:
- clk  input  1  system clock (vclk domain), rising edge.
- rst  input  1  asynchronous, active-high reset.
- kd  input  8  received scancode byte, valid when kv=1.
- kv  input  1  one-cycle byte strobe from the keyboard receiver; may assert on consecutive cycles.
- ev_code  output  8  head event scancode (final byte of the sequence).
- ev_ext  output  1  head event was E0-prefixed.
- ev_brk  output  1  head event is a release (F0-prefixed).
- ev_valid  output  1  FIFO non-empty.
- ev_ready  input  1  consumer accepts head entry when ev_valid & ev_ready.
- ovf  output  1  sticky: an event was dropped because the FIFO was full.
- ovf_clr  input  1  clears ovf; a same-cycle drop wins (ovf stays 1).
- level  output  DEPTH_LOG2+1  number of queued events, 0..DEPTH.

Behaviour:
- Reset: async; all outputs 0, FSM to IDLE, skip counter 0, FIFO empty.
- Reset mid-sequence discards any partial prefix state.
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP. Transitions apply only on kv=1:
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> SKIP with skip count = 7.
  - IDLE: bytes 00, AA, EE, FA, FE, FF are discarded; the state stays IDLE.
  - IDLE: any other byte pushes {ext=0, brk=0, code} and stays IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> EXT (redundant prefix ignored); any other byte pushes {ext=1, brk=0, code} -> IDLE.
  - BRK: any byte except E0/F0 pushes {0, 1, code} -> IDLE; E0 -> EXT_BRK; F0 stays in BRK.
  - EXT_BRK: any byte except E0/F0 pushes {1, 1, code} -> IDLE; E0/F0 are ignored.
  - SKIP: each byte decrements the counter; the 7th byte returns to IDLE. Nothing is pushed (pause key is ignored).
- Push timing: the push occurs in the cycle kv is sampled high. The entry is visible at ev_valid/ev_code from the next cycle (1-cycle latency).
- FIFO organisation: DEPTH entries of 10 bits {ext, brk, code}. Circular read/write pointers with natural wrap at DEPTH. Outputs are driven from the head entry (FWFT).
- Pop: ev_valid & ev_ready advances the read pointer. ev_ready while empty has no effect.
- Full, push without pop: the event is dropped, ovf is set, and the FIFO contents are unchanged.
- Full, push and pop in the same cycle: the push is accepted; level stays DEPTH.
- Empty, push and pop in the same cycle: the pop is ignored (ev_valid was 0); level becomes 1.
- level updates on the same edge as the pointers: +1 on push only, -1 on pop only, unchanged on both or neither.

Optional Feature:
- Macro: KBD_EVENT_FIFO_REPEAT_FILTER_EN.
- When defined, the block tracks the last make event's {ext, code} plus a "held" flag.
  - A make event that matches the held key is suppressed (typematic repeat), with no push and no ovf.
  - A break whose {ext, code} matches the held key clears "held".
  - Any other make replaces the held key.
  - Reset clears "held".
- When undefined, every make, including typematic repeats, is pushed.

Test Plan:
1. Reset, then kv bytes 1C -> one entry {ext=0, brk=0, code=1C}, ev_valid=1 one cycle after the strobe, level=1.
2. Bytes E0 F0 75 back-to-back with ev_ready=0 -> single entry {1, 1, 75}, level=1. Then assert ev_ready for one cycle -> level=0, ev_valid=0.
3. Push 17 make codes 01..11 with ev_ready=0 -> level=16, ovf=1, head=01. Pulse ovf_clr -> ovf=0. Drain -> codes 01..10 in order.
4. Full FIFO; push 2A on the same cycle as a pop -> level stays 16, ovf stays 0, last entry read out is 2A.
5. Bytes AA, FA, E1 14 77 E1 F0 14 F0 77, then 1C -> only {0, 0, 1C} queued. Assert rst between E0 and 75 -> no entry; a subsequent 75 yields {0, 0, 75}.
6. Filter macro defined: bytes 1C 1C 1C F0 1C 1C -> entries make 1C, break 1C, make 1C (level=3). Without the macro, level=5.
